// File: rtl/updn_cnt_pkg.sv
// updn_cnt_pkg: shared direction/mode constants and load clamping for the up/down counter
package updn_cnt_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DN    = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Loaded values above the top count are pulled down to it so q never leaves 0..max
    function automatic logic [31:0] clamp_load(input logic [31:0] value, input logic [31:0] max);
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/updn_next_val.sv
// updn_next_val: combinational next count and boundary flags for the up/down counter
module updn_next_val
    import updn_cnt_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX_VAL = 2**WIDTH-1
) (
    input  logic [WIDTH-1:0] q,
    input  logic             dir,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] next_q,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] W_MAX = MAX_VAL[WIDTH-1:0];

    // Boundaries are checked before stepping, so the step itself can never leave 0..MAX_VAL
    always_comb begin
        at_max = (q == W_MAX);
        at_min = (q == '0);
        next_q = (dir == DIR_UP)
               ? (at_max ? ((sat_mode == MODE_SAT) ? W_MAX : '0) : q + WIDTH'(1))
               : (at_min ? ((sat_mode == MODE_SAT) ? '0 : W_MAX) : q - WIDTH'(1));
    end

endmodule

// File: rtl/updn_counter_mod.sv
// updn_counter_mod: modulo up/down counter with load, wrap/saturate, terminal count and
// overflow/underflow pulses; define UPDN_CASCADE_EN to add cin/cout for chaining digits
module updn_counter_mod
    import updn_cnt_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX_VAL = 2**WIDTH-1,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
`ifdef UPDN_CASCADE_EN
    input  logic             cin,
`endif
    input  logic             dir,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef UPDN_CASCADE_EN
    output logic             cout,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    logic [WIDTH-1:0] r_q;
    logic             r_ovf;
    logic             r_unf;
    logic [WIDTH-1:0] w_next_q;
    logic [WIDTH-1:0] w_load_q;
    logic             w_at_max;
    logic             w_at_min;
    logic             w_en;

`ifdef UPDN_CASCADE_EN
    assign w_en = en & cin;
    assign cout = tc;
`else
    assign w_en = en;
`endif

    assign w_load_q = WIDTH'(clamp_load(32'(load_val), 32'(MAX_VAL)));

    updn_next_val #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_next (
        .q        (r_q),
        .dir      (dir),
        .sat_mode (sat_mode),
        .next_q   (w_next_q),
        .at_max   (w_at_max),
        .at_min   (w_at_min)
    );

    // Count register with load taking priority over enable; boundary pulses last one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q   <= WIDTH'(RST_VAL);
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (load) begin
            r_q   <= w_load_q;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_q   <= w_en ? w_next_q : r_q;
            r_ovf <= w_en & (dir == DIR_UP) & w_at_max;
            r_unf <= w_en & (dir == DIR_DN) & w_at_min;
        end
    end

    assign q   = r_q;
    assign ovf = r_ovf;
    assign unf = r_unf;
    assign tc  = w_en & (((dir == DIR_UP) & w_at_max) | ((dir == DIR_DN) & w_at_min));

endmodule
